// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative MIPS multiply/divide unit.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  localparam int          MD_ITER    = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/mips_cpu_muldiv_absneg.sv
// Conditional two's-complement negate; used for operand magnitudes and the sign fix.
module mips_cpu_muldiv_absneg #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; sole writer of the HI/LO block.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_data_hi,
  output logic [WIDTH-1:0] write_data_lo
);

  md_state_t          state;
  logic [5:0]         cnt;
  logic               is_div_q;
  logic               neg_q;
  logic               sa_q;
  logic               div0_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   mag_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in, abs_a_out, abs_b_out;
  logic               abs_a_neg, abs_b_neg;
  logic [2*WIDTH-1:0] fix_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);

  // The two narrow negators take operand magnitudes at start and fix remainder/quotient signs in FIX.
  always_comb begin
    if (state == ST_FIX) begin
      abs_a_in  = acc_q[2*WIDTH-1:WIDTH];
      abs_a_neg = sa_q;
      abs_b_in  = acc_q[WIDTH-1:0];
      abs_b_neg = neg_q;
    end else begin
      abs_a_in  = op_a;
      abs_a_neg = op_signed & op_a[WIDTH-1];
      abs_b_in  = op_b;
      abs_b_neg = op_signed & op_b[WIDTH-1];
    end
  end

  mips_cpu_muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
    .din (abs_a_in),
    .neg (abs_a_neg),
    .dout(abs_a_out)
  );

  mips_cpu_muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
    .din (abs_b_in),
    .neg (abs_b_neg),
    .dout(abs_b_out)
  );

  mips_cpu_muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix (
    .din (acc_q),
    .neg (neg_q),
    .dout(fix_out)
  );

  // Shift-add: upper half accumulates, lower half holds the shrinking multiplier.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, mag_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      write_enable  <= 1'b0;
      write_data_hi <= '0;
      write_data_lo <= '0;
      cnt           <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      sa_q          <= 1'b0;
      div0_q        <= 1'b0;
      a_raw_q       <= '0;
      mag_q         <= '0;
      acc_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div_q <= (op == MD_DIV) || (op == MD_DIVU);
            neg_q    <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sa_q     <= op_signed & op_a[WIDTH-1];
            div0_q   <= (op_b == '0);
            a_raw_q  <= op_a;
            cnt      <= '0;
            case (op)
              MD_MULT, MD_MULTU: begin
                state <= ST_MUL;
                busy  <= 1'b1;
                mag_q <= abs_a_out;
                acc_q <= {{WIDTH{1'b0}}, abs_b_out};
              end
              MD_DIV, MD_DIVU: begin
                state <= ST_DIV;
                busy  <= 1'b1;
                mag_q <= abs_b_out;
                acc_q <= {{WIDTH{1'b0}}, abs_a_out};
              end
              MD_MTHI: begin
                state         <= ST_DONE;
                busy          <= 1'b1;
                write_enable  <= 1'b1;
                write_data_hi <= op_a;
                write_data_lo <= lo_in;
              end
              MD_MTLO: begin
                state         <= ST_DONE;
                busy          <= 1'b1;
                write_enable  <= 1'b1;
                write_data_hi <= hi_in;
                write_data_lo <= op_a;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= (state == ST_MUL) ? mul_next : div_next;
          if (cnt == 6'(MD_ITER - 1)) begin
            state <= ST_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_FIX: begin
          state        <= ST_DONE;
          write_enable <= 1'b1;
          if (is_div_q && div0_q) begin
            write_data_hi <= a_raw_q;
            write_data_lo <= MD_DIV0_LO;
          end else if (is_div_q) begin
            write_data_hi <= abs_a_out;
            write_data_lo <= abs_b_out;
          end else begin
            write_data_hi <= fix_out[2*WIDTH-1:WIDTH];
            write_data_lo <= fix_out[WIDTH-1:0];
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          write_enable <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: driver pushes model results, monitor checks each HI/LO write.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  md_op_t      op;
  logic [31:0] op_a, op_b, hi_in, lo_in;
  logic        busy, write_enable;
  logic [31:0] write_data_hi, write_data_lo;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .op_a         (op_a),
    .op_b         (op_b),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .busy         (busy),
    .write_enable (write_enable),
    .write_data_hi(write_data_hi),
    .write_data_lo(write_data_lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          pushed = 0;
  int          we_seen = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // Reference: MIPS HI/LO results from plain 64-bit arithmetic.
  function automatic logic [63:0] model(md_op_t o, logic [31:0] a, logic [31:0] b,
                                        logic [31:0] h, logic [31:0] l);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    res = '0;
    case (o)
      MD_MULT:  res = 64'(sa * sbv);
      MD_MULTU: res = 64'(ua * ub);
      MD_DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      MD_MTHI:  res = {a, l};
      MD_MTLO:  res = {h, a};
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (!reset && write_enable) begin
      exp_t e;
      we_seen++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: hi=0x%0h lo=0x%0h with nothing outstanding",
                 write_data_hi, write_data_lo);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(write_data_hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(write_data_lo), 64'(e.lo));
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  // Presents one start pulse; returns at the negedge of the cycle after start.
  task automatic issue(md_op_t o, logic [31:0] a, logic [31:0] b, logic [31:0] h,
                       logic [31:0] l, string nm, bit expect_result);
    logic [63:0] r;
    exp_t        e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    hi_in = h;
    lo_in = l;
    if (expect_result && (o <= MD_MTLO)) begin
      r      = model(o, a, b, h, l);
      e.hi   = r[63:32];
      e.lo   = r[31:0];
      e.at   = cyc + ((o >= MD_MTHI) ? 1 : 34);
      e.name = nm;
      sb.push_back(e);
      pushed++;
    end
    @(negedge clk);
    start = 1'b0;
    op    = md_op_t'($urandom_range(0, 7));
    op_a  = $urandom;
    op_b  = $urandom;
    hi_in = $urandom;
    lo_in = $urandom;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((busy || write_enable) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle_in_time"}, 64'(n < 100), 64'(1));
    check({nm, "_drained"}, 64'(sb.size()), 64'(0));
    check({nm, "_hold"}, {write_data_hi, write_data_lo}, {last_hi, last_lo});
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000007};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = MD_MULT;
    op_a  = '0;
    op_b  = '0;
    hi_in = '0;
    lo_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_we", 64'(write_enable), 64'(0));
    check("reset_data", {write_data_hi, write_data_lo}, 64'(0));
    reset = 1'b0;

    // MULTU max*max with cycle-by-cycle busy / strobe profile
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, "multu_max", 1'b1);
    for (int i = 1; i <= 35; i++) begin
      check($sformatf("multu_busy_k+%0d", i), 64'(busy), 64'(i <= 34));
      check($sformatf("multu_we_k+%0d", i), 64'(write_enable), 64'(i == 34));
      if (i < 35) @(negedge clk);
    end
    wait_idle("multu_max");

    issue(MD_MULT, 32'hFFFFFFFD, 32'd7, '0, '0, "mult_neg3x7", 1'b1);
    wait_idle("mult_neg3x7");
    issue(MD_MULT, 32'h80000000, 32'h80000000, '0, '0, "mult_minxmin", 1'b1);
    wait_idle("mult_minxmin");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, '0, '0, "div_neg7by2", 1'b1);
    wait_idle("div_neg7by2");
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, '0, '0, "div_min_by_m1", 1'b1);
    wait_idle("div_min_by_m1");
    issue(MD_DIVU, 32'd100, 32'd7, '0, '0, "divu_100by7", 1'b1);
    wait_idle("divu_100by7");

    // Divide by zero, with an MTLO request arriving mid-operation that must be dropped
    issue(MD_DIVU, 32'h64, 32'h0, '0, '0, "divu_by0", 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = MD_MTLO;
    op_a  = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    wait_idle("divu_by0");
    check("divu_by0_single_write", 64'(we_seen), 64'(pushed));
    issue(MD_DIV, 32'hFFFFFF00, 32'h0, '0, '0, "div_neg_by0", 1'b1);
    wait_idle("div_neg_by0");

    issue(MD_MTHI, 32'hDEADBEEF, 32'h0, 32'hAAAA5555, 32'h12345678, "mthi", 1'b1);
    wait_idle("mthi");
    issue(MD_MTLO, 32'hDEADBEEF, 32'h0, 32'h12345678, 32'hAAAA5555, "mtlo", 1'b1);
    wait_idle("mtlo");

    issue(md_op_t'(3'd6), 32'h1, 32'h2, '0, '0, "op6", 1'b1);
    check("op6_not_busy", 64'(busy), 64'(0));
    wait_idle("op6");

    // Asynchronous reset at iteration 10 aborts the MULT without a write
    issue(MD_MULT, 32'h12345, 32'hFFFF0001, '0, '0, "mult_abort", 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_we", 64'(write_enable), 64'(0));
    check("abort_data", {write_data_hi, write_data_lo}, 64'(0));
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_write", 64'(we_seen), 64'(pushed));
    issue(MD_MULTU, 32'd3, 32'd5, '0, '0, "multu_3x5", 1'b1);
    wait_idle("multu_3x5");

    // Randomized mix, with occasional ignored start pulses while busy
    for (int n = 0; n < 40; n++) begin
      md_op_t o;
      o = md_op_t'($urandom_range(0, 7));
      issue(o, rand_val(), rand_val(), $urandom, $urandom, $sformatf("rand%0d", n), 1'b1);
      if (o <= MD_DIVU && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        start = 1'b1;
        op    = md_op_t'($urandom_range(0, 7));
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle($sformatf("rand%0d", n));
    end
    check("total_writes", 64'(we_seen), 64'(pushed));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
